// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller and its
// demux-based full-adder cell.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Demux lines that are high for an odd number of ones / a majority of ones.
  localparam logic [7:0] SUM_MASK   = 8'b1001_0110;
  localparam logic [7:0] CARRY_MASK = 8'b1110_1000;

  // Bit counter width; never below 1 so a single-bit adder still has a counter.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/fa_demux_cell.sv
// Combinational 1-bit full adder built from a 1-to-8 demux whose outputs are
// OR-reduced through fixed decode masks.
module fa_demux_cell
  import serial_adder_pkg::*;
(
  input  logic       din_i,
  input  logic [2:0] sel_i,
  output logic       sum_o,
  output logic       carry_o
);

  logic [7:0] y;

  always_comb begin
    y        = 8'b0;
    y[sel_i] = din_i;
  end

  assign sum_o   = |(y & SUM_MASK);
  assign carry_o = |(y & CARRY_MASK);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell iterated WIDTH times,
// LSB first, with a registered result and a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cell_sum, cell_carry;
  logic [WIDTH-1:0] sum_shift;

  fa_demux_cell u_cell (
    .din_i   (state_q == RUN),
    .sel_i   ({a_sr_q[0], b_sr_q[0], carry_q}),
    .sum_o   (cell_sum),
    .carry_o (cell_carry)
  );

  // New sum bit enters at the MSB so the LSB-first result lands aligned.
  assign sum_shift = (sum_sr_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift;
        carry_d  = cell_carry;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Publish the final bit together with the rest of the result.
          sum_d   = sum_shift;
          cout_d  = cell_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1; monitors pop
// expected results whenever done is seen.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [7:0] s;
    logic       co;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  exp_t q8[$];
  exp_t q1[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        $display("[TB] w8 done cyc=%0d sum=%02h cout=%0b", cyc, sum8, cout8);
        chk("w8_sum", sum8, e.s);
        chk("w8_cout", cout8, e.co);
        chk("w8_done_cycle", cyc, e.cyc);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        $display("[TB] w1 done cyc=%0d sum=%0b cout=%0b", cyc, sum1, cout1);
        chk("w1_sum", sum1, e.s[0]);
        chk("w1_cout", cout1, e.co);
        chk("w1_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issues one request; operands are scrambled right after acceptance.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [7:0] es, input logic ec);
    exp_t e;
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    e.s = es; e.co = ec; e.cyc = cyc + 9;
    q8.push_back(e);
    step(1);
    start8 = 1'b0;
    a8 = ~av; b8 = ~bv; cin8 = ~cv;
  endtask

  task automatic wait_idle8();
    int n;
    n = 0;
    while (busy8 && n < 40) begin
      step(1);
      n++;
    end
    chk("w8_idle_bound", busy8, 0);
  endtask

  task automatic issue1(input logic av, input logic bv, input logic cv,
                        input logic es, input logic ec);
    exp_t e;
    int n;
    a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
    e.s = {7'b0, es}; e.co = ec; e.cyc = cyc + 2;
    q1.push_back(e);
    step(1);
    start1 = 1'b0;
    a1 = ~av; b1 = ~bv; cin1 = ~cv;
    n = 0;
    while (busy1 && n < 10) begin
      step(1);
      n++;
    end
    chk("w1_idle_bound", busy1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] tot;
    // {a, b, cin, sum, cout} for the single-bit adder, worked by hand.
    logic [4:0] w1_tab [8] = '{5'b000_0_0, 5'b001_1_0, 5'b010_1_0, 5'b011_0_1,
                               5'b100_1_0, 5'b101_0_1, 5'b110_0_1, 5'b111_1_1};

    step(3);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    step(2);

    // 0x5A + 0x3C: busy for relative cycles 1..9, done only at 9.
    issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    for (int r = 1; r <= 10; r++) begin
      chk("w8_busy_profile", busy8, (r <= 9) ? 1 : 0);
      step(1);
    end

    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_idle8();
    issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    wait_idle8();

    // start held high: acceptances every 10 cycles, junk operands while busy.
    c = cyc;
    start8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.s = 8'h03; e.co = 1'b0; e.cyc = c + 9 + 10 * k;
      q8.push_back(e);
    end
    for (int i = 0; i <= 20; i++) begin
      if (i % 10 == 0) begin
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      step(1);
    end
    start8 = 1'b0;
    wait_idle8();

    // Abort 0xAA + 0x55 with reset in relative cycle 4; no done may follow.
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    step(1);
    start8 = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    step(12);
    chk("abort_stays_idle", busy8, 0);

    issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    wait_idle8();

    for (int i = 0; i < 8; i++) begin
      issue1(w1_tab[i][4], w1_tab[i][3], w1_tab[i][2], w1_tab[i][1], w1_tab[i][0]);
    end

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      tot = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      issue8(ra, rb, rc, tot[7:0], tot[8]);
      wait_idle8();
    end

    step(3);
    chk("w8_queue_drained", q8.size(), 0);
    chk("w1_queue_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
